lcd_tx_scheduler: RTL and testbench

LCD_TX_SCHEDULER -- requirements
Module: lcd_tx_scheduler

---
 rtl/lcd_tx_scheduler_pkg.sv | 19 +
 rtl/lcd_cmd_fifo.sv | 40 ++++
 rtl/lcd_tx_scheduler.sv | 102 ++++++++++
 tb/tb_lcd_tx_scheduler.sv | 138 +++++++++++++
 4 files changed

// File: rtl/lcd_tx_scheduler_pkg.sv
// lcd_tx_scheduler_pkg: shared FSM encoding, bus field positions and sizing helper.
package lcd_tx_scheduler_pkg;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PULSE, S_GAP} state_t;
  localparam int D_CHAR_LSB = 0;
  localparam int D_CHAR_MSB = 7;
  localparam int D_CLEAR = 9;
  localparam int D_OVF_CLR = 31;
  localparam int E_CLEAR = 8;
  localparam int RD_OVF = 31;
  localparam int RD_BUSY = 16;
  localparam int RD_CNT_LSB = 8;
  localparam int RD_FULL = 1;
  localparam int RD_EMPTY = 0;
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction
endpackage

// File: rtl/lcd_cmd_fifo.sv
// lcd_cmd_fifo: synchronous command FIFO with registered occupancy count.
module lcd_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 9
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_data,
  output logic [W-1:0]             o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_count;
  logic w_push_ok, w_pop_ok;
  assign o_full = r_count == (AW+1)'(DEPTH);
  assign o_empty = r_count == '0;
  assign o_count = r_count;
  assign o_data = r_mem[r_rd];
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok = i_pop & ~o_empty;
  always_ff @(posedge clk)
    if (w_push_ok) r_mem[r_wr] <= i_data;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wr <= r_wr + AW'(1);
      if (w_pop_ok) r_rd <= r_rd + AW'(1);
      r_count <= r_count + (AW+1)'(w_push_ok) - (AW+1)'(w_pop_ok);
    end
  end
endmodule

// File: rtl/lcd_tx_scheduler.sv
// lcd_tx_scheduler: queues bus-written LCD commands and paces strobes to the LCD driver.
// Define LCD_SCHED_STATUS_EN to expose the status word on rdata (otherwise rdata reads 0).
module lcd_tx_scheduler
  import lcd_tx_scheduler_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES = 2000,
  parameter int CLEAR_GAP_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        w_en,
  input  logic [31:0] d,
  output logic [31:0] rdata,
  output logic        full,
  output logic        empty,
  output logic        busy,
  output logic [7:0]  lcd_info,
  output logic        lcd_enviar,
  output logic        lcd_limpiar
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(max3(PULSE_CYCLES, GAP_CYCLES, CLEAR_GAP_CYCLES) + 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
  state_t r_state;
  logic [CW-1:0] r_cnt;
  logic [8:0] r_cmd;
  logic [7:0] r_info;
  logic r_ovf, r_busy, r_enviar, r_limpiar;
  logic w_push, w_pop, w_gap_done, w_unused;
  logic [8:0] w_head;
  logic [AW:0] w_count;
  logic [CW-1:0] w_gap_last;
  assign w_push = w_en & ~d[D_OVF_CLR];
  assign w_gap_last = r_cmd[E_CLEAR] ? CW'(CLEAR_GAP_CYCLES - 1) : CW'(GAP_CYCLES - 1);
  assign w_gap_done = r_state == S_GAP && r_cnt == w_gap_last;
  // The end of a gap pops directly so back-to-back commands skip the idle cycle.
  assign w_pop = ~empty & (r_state == S_IDLE || w_gap_done);
  assign w_unused = ^{d[30:10], d[8], r_ovf, w_count};
  lcd_cmd_fifo #(.DEPTH(DEPTH), .W(9)) u_fifo (
    .clk(clk),
    .reset(reset),
    .i_push(w_push),
    .i_pop(w_pop),
    .i_data({d[D_CLEAR], d[D_CHAR_MSB:D_CHAR_LSB]}),
    .o_data(w_head),
    .o_full(full),
    .o_empty(empty),
    .o_count(w_count)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt <= '0;
      r_cmd <= '0;
      r_info <= '0;
      r_ovf <= 1'b0;
      r_busy <= 1'b0;
      r_enviar <= 1'b0;
      r_limpiar <= 1'b0;
    end else begin
      r_busy <= r_state != S_IDLE;
      r_enviar <= r_state == S_PULSE && !r_cmd[E_CLEAR];
      r_limpiar <= r_state == S_PULSE && r_cmd[E_CLEAR];
      r_ovf <= (w_en && d[D_OVF_CLR]) ? 1'b0 : (w_en && full) ? 1'b1 : r_ovf;
      if (w_pop) r_cmd <= w_head;
      case (r_state)
        S_IDLE: if (w_pop) r_state <= S_LOAD;
        S_LOAD: begin
          r_info <= r_cmd[7:0];
          r_cnt <= '0;
          r_state <= S_PULSE;
        end
        S_PULSE: begin
          r_cnt <= (r_cnt == PULSE_LAST) ? '0 : r_cnt + CW'(1);
          if (r_cnt == PULSE_LAST) r_state <= S_GAP;
        end
        S_GAP: begin
          r_cnt <= w_gap_done ? '0 : r_cnt + CW'(1);
          if (w_gap_done) r_state <= w_pop ? S_LOAD : S_IDLE;
        end
      endcase
    end
  end
  assign busy = r_busy;
  assign lcd_info = r_info;
  assign lcd_enviar = r_enviar;
  assign lcd_limpiar = r_limpiar;
`ifdef LCD_SCHED_STATUS_EN
  always_comb begin
    rdata = '0;
    rdata[RD_OVF] = r_ovf;
    rdata[RD_BUSY] = r_busy;
    rdata[RD_CNT_LSB +: 8] = 8'(w_count);
    rdata[RD_FULL] = full;
    rdata[RD_EMPTY] = empty;
  end
`else
  assign rdata = '0;
`endif
endmodule

// File: tb/tb_lcd_tx_scheduler.sv
// tb_lcd_tx_scheduler: directed checks of latency, pacing, clear, overflow and reset behaviour.
module tb_lcd_tx_scheduler;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic w_en = 1'b0;
  logic [31:0] d = '0;
  logic [31:0] rdata;
  logic full, empty, busy, lcd_enviar, lcd_limpiar;
  logic [7:0] lcd_info;
  int checks = 0;
  int errors = 0;
`ifdef LCD_SCHED_STATUS_EN
  localparam logic [31:0] RD_RST = 32'h0000_0001;
  localparam logic [31:0] RD_OVF = 32'h8001_0402;
  localparam logic [31:0] RD_OCLR = 32'h0001_0402;
  localparam logic [31:0] RD_END = 32'h0000_0001;
`else
  localparam logic [31:0] RD_RST = 32'h0;
  localparam logic [31:0] RD_OVF = 32'h0;
  localparam logic [31:0] RD_OCLR = 32'h0;
  localparam logic [31:0] RD_END = 32'h0;
`endif
  lcd_tx_scheduler #(
    .DEPTH(4),
    .PULSE_CYCLES(4),
    .GAP_CYCLES(10),
    .CLEAR_GAP_CYCLES(50)
  ) dut (
    .clk(clk),
    .reset(reset),
    .w_en(w_en),
    .d(d),
    .rdata(rdata),
    .full(full),
    .empty(empty),
    .busy(busy),
    .lcd_info(lcd_info),
    .lcd_enviar(lcd_enviar),
    .lcd_limpiar(lcd_limpiar)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    step();
    step();
    reset = 1'b0;
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_busy", busy, 0);
    check("rst_env", lcd_enviar, 0);
    check("rst_limp", lcd_limpiar, 0);
    check("rst_info", lcd_info, 0);
    check("rst_rdata", rdata, RD_RST);
    // single character: write at edge N, strobe N+3..N+6, idle at N+17
    w_en = 1'b1;
    d = 32'h41;
    step();
    w_en = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      step();
      check("char_env", lcd_enviar, 32'(i >= 3 && i <= 6));
      check("char_limp", lcd_limpiar, 0);
      if (i >= 2) check("char_info", lcd_info, 32'h41);
      if (i == 16) check("char_busy_hi", busy, 1);
      if (i == 17) check("char_busy_lo", busy, 0);
    end
    check("char_empty", empty, 1);
    // clear followed by a queued character: rises 55 cycles apart
    w_en = 1'b1;
    d = 32'h200;
    step();
    d = 32'h42;
    step();
    w_en = 1'b0;
    for (int i = 2; i <= 74; i++) begin
      step();
      check("clr_limp", lcd_limpiar, 32'(i >= 3 && i <= 6));
      check("clr_env", lcd_enviar, 32'(i >= 58 && i <= 61));
      if (i == 3) check("clr_info", lcd_info, 32'h00);
      if (i == 58) check("clr_next_info", lcd_info, 32'h42);
    end
    check("clr_busy", busy, 0);
    check("clr_empty", empty, 1);
    // overflow: A..F back to back, F dropped; overflow cleared at i=7
    for (int i = 0; i <= 80; i++) begin
      w_en = (i < 6) || (i == 7);
      d = (i == 7) ? 32'h8000_0000 : 32'(8'h41 + i);
      step();
      check("ovf_env", lcd_enviar, 32'(i >= 3 && i < 78 && (i - 3) % 15 < 4));
      check("ovf_limp", lcd_limpiar, 0);
      if (i >= 3 && i <= 63 && (i - 3) % 15 == 0) check("ovf_info", lcd_info, 32'(8'h41 + (i - 3) / 15));
      if (i == 5) begin
        check("ovf_full", full, 1);
        check("ovf_rdata", rdata, RD_OVF);
      end
      if (i == 7) begin
        check("oclr_full", full, 1);
        check("oclr_rdata", rdata, RD_OCLR);
      end
    end
    w_en = 1'b0;
    check("ovf_end_empty", empty, 1);
    check("ovf_end_busy", busy, 0);
    check("ovf_end_rdata", rdata, RD_END);
    // reset on the second edge of a pulse with three entries queued
    for (int i = 0; i <= 4; i++) begin
      w_en = i < 4;
      d = 32'h61 + 32'(i);
      reset = i == 4;
      step();
      if (i == 3) check("mid_env_hi", lcd_enviar, 1);
    end
    reset = 1'b0;
    w_en = 1'b0;
    check("mid_env_lo", lcd_enviar, 0);
    check("mid_empty", empty, 1);
    check("mid_busy", busy, 0);
    check("mid_info", lcd_info, 0);
    for (int i = 0; i < 30; i++) begin
      step();
      check("mid_quiet_env", lcd_enviar, 0);
      check("mid_quiet_limp", lcd_limpiar, 0);
    end
    check("mid_end_empty", empty, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
